fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS datapath. Holds the PC, issues instruction-memory requests over a valid/accept handshake, and presents the fetched instruction and its PC+4 to the decode stage, where the controller consumes them. Takes redirects (branch, j/jal, jr) and stalls from decode and the hazard unit, flushing wrong-path instructions and discarding in-flight memory responses after a redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- Stall  in  1  hazard unit; hold PC and IF/ID
- Branch  in  1  decode redirect request (taken branch, j, jal, jr)
- jump  in  1  redirect target is the J-format target
- jr  in  1  redirect target is JrTarget; priority over jump
- BranchTarget  in  32  PC+4 + (sext(imm) << 2), computed in decode
- JrTarget  in  32  forwarded rs value
- ImemReq  out  1  request valid
- ImemAddr  out  32  word address of request (PC)
- ImemValid  in  1  response valid; memory holds ImemData until accepted
- ImemData  in  32  instruction word
- ImemAccept  out  1  response consumed this cycle
- Instruction  out  32  IF/ID instruction; 32'h0 (nop) when bubble
- PCPlus4  out  32  IF/ID PC+4 (jal link value)
- IdValid  out  1  IF/ID holds a real instruction

## Operation
- FSM states: FETCH (normal), DISCARD (waiting to drop a wrong-path response).
- ImemReq = Reset && (state is FETCH or DISCARD). ImemAddr = PC. ImemAddr is stable while a request is outstanding.
- Redirect = Branch && IdValid && !Stall. Target: jr → JrTarget; else jump → {PCPlus4[31:28], Instruction[25:0], 2'b00}; else BranchTarget.
- ImemAccept: FETCH → ImemValid && (!Stall || Redirect). Redirect already implies !Stall, so in FETCH this is effectively ImemValid && !Stall. DISCARD → ImemValid.
- FETCH, no redirect, accept: PC ← PC+4; Instruction ← ImemData; PCPlus4 ← PC+4; IdValid ← 1.
- FETCH, no redirect, !Stall, !ImemValid: IF/ID ← bubble (Instruction 0, IdValid 0). PC is held.
- FETCH, Stall: PC, IF/ID and state are held. The response is not accepted.
- FETCH, redirect, ImemValid: the response is accepted and dropped. PC ← target. IF/ID ← bubble. State stays FETCH.
- FETCH, redirect, !ImemValid: PendingPC ← target. IF/ID ← bubble. State goes to DISCARD. ImemAddr stays at the old PC.
- DISCARD, ImemValid: the response is dropped. PC ← PendingPC. State goes to FETCH.
- DISCARD, !ImemValid: hold. IF/ID stays a bubble regardless of Stall.
- Redirect cannot occur in DISCARD because IdValid is 0. Branch is ignored there.
- All PC arithmetic is 32-bit unsigned and wraps mod 2^32; 32'hFFFF_FFFC + 4 → 0.

## Timing
- Reset (Reset=0 at an edge): PC=RESET_PC, state FETCH, PendingPC=0, Instruction=0, PCPlus4=0, IdValid=0.
- While Reset=0: ImemReq=0 and ImemAccept=0.
- Reset mid-DISCARD abandons the outstanding response. Memory must also be reset.
- With a zero-wait memory (ImemValid same cycle as ImemReq): one instruction per cycle; ID sees the instruction 1 cycle after its address is on ImemAddr.
- Redirect penalty with a zero-wait memory: 1 bubble. Add one further bubble per memory wait cycle during DISCARD.
- Stall and Branch in the same cycle: Stall wins. Decode re-presents Branch after the stall.
- All outputs except ImemReq and ImemAccept are registered. ImemReq and ImemAccept are combinational from state, Stall, Redirect and ImemValid.

## Configuration
- FETCH_PERF_EN defined: adds three 32-bit wrapping outputs, each cleared by reset:
  - FetchCount: accepted, non-dropped responses.
  - StallCount: cycles with Stall=1 in FETCH.
  - FlushCount: redirects.
- FETCH_PERF_EN undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package pipeline_pkg:
  - NOP_INSTR = 32'h0.
  - fetch_state_t enum {FETCH, DISCARD}.
  - Opcode/funct constants for j (000010), jal (000011), jr (000000/001000), shared with decode.
- One sub-module, fetch_target_mux: combinational jr/jump/branch target select.

## Test plan
- Reset with RESET_PC=32'h0040_0000, zero-wait memory, no stall → ImemAddr 0x00400000, 0x00400004, 0x00400008 on successive cycles. PCPlus4 lags by one cycle (0x00400004 first). IdValid rises 1 cycle after reset release.
- Stall=1 for 3 cycles with ImemValid=1 → PC, Instruction and IdValid are frozen and ImemAccept=0. The first cycle after stall release accepts the held word.
- Branch=1, IdValid=1, BranchTarget=0x00400100, ImemValid=1 → next ImemAddr is 0x00400100. The next IF/ID is a bubble (Instruction 0, IdValid 0).
- jr=1 with JrTarget=0x00400200, jump=1 also asserted → target is 0x00400200.
- Redirect with ImemValid low for 2 more cycles → state DISCARD and ImemAddr holds the old PC. The late response is dropped (IdValid stays 0). The next request is to the target.
- Reset=0 asserted while in DISCARD → next cycle: state FETCH, PC=RESET_PC, IdValid=0, ImemReq=0 while reset is held.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: NOP encoding, fetch FSM states, and the
// j/jal/jr opcode and funct constants used by both fetch and decode.
package pipeline_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FUNCT_JR = 6'b001000;

   typedef enum logic {
      FETCH   = 1'b0,
      DISCARD = 1'b1
   } fetch_state_t;

   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   // J-format target: top nibble of the delay-slot PC plus the word index.
   function automatic logic [31:0] jump_target(input logic [3:0]  pc_hi,
                                               input logic [25:0] index);
      return {pc_hi, index, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and instruction memory.
interface fetch_stage_if;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemValid;
   logic [31:0] ImemData;
   logic        ImemAccept;

   modport master (output ImemReq, output ImemAddr, output ImemAccept,
                   input  ImemValid, input ImemData);
   modport slave  (input  ImemReq, input ImemAddr, input ImemAccept,
                   output ImemValid, output ImemData);
endinterface

// File: rtl/fetch_target_mux.sv
// Redirect target select: jr beats jump, jump beats the branch target.
module fetch_target_mux
   import pipeline_pkg::*;
(
   input  logic        jr,
   input  logic        jump,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] JrTarget,
   input  logic [3:0]  pc_hi,
   input  logic [25:0] instr_index,
   output logic [31:0] target
);

   always_comb begin
      target = BranchTarget;
      if (jr)
         target = JrTarget;
      else if (jump)
         target = jump_target(pc_hi, instr_index);
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and wrong-path response discard.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Branch,
   input  logic        jump,
   input  logic        jr,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] JrTarget,
   fetch_stage_if.master imem,
   output logic [31:0] Instruction,
   output logic [31:0] PCPlus4,
   output logic        IdValid
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] FetchCount,
   output logic [31:0] StallCount,
   output logic [31:0] FlushCount
`endif
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  pending_pc;
   logic [31:0]  target;
   logic         redirect;

   fetch_target_mux u_target_mux (
      .jr           (jr),
      .jump         (jump),
      .BranchTarget (BranchTarget),
      .JrTarget     (JrTarget),
      .pc_hi        (PCPlus4[31:28]),
      .instr_index  (Instruction[25:0]),
      .target       (target)
   );

   assign redirect        = (state == FETCH) && Branch && IdValid && !Stall;
   assign imem.ImemReq    = Reset && ((state == FETCH) || (state == DISCARD));
   assign imem.ImemAddr   = pc;
   assign imem.ImemAccept = Reset && ((state == FETCH) ? (imem.ImemValid && (!Stall || redirect))
                                                       : imem.ImemValid);

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         pending_pc  <= 32'h0;
         Instruction <= NOP_INSTR;
         PCPlus4     <= 32'h0;
         IdValid     <= 1'b0;
`ifdef FETCH_PERF_EN
         FetchCount  <= 32'h0;
         StallCount  <= 32'h0;
         FlushCount  <= 32'h0;
`endif
      end else begin
         case (state)
            FETCH: begin
               if (Stall) begin
`ifdef FETCH_PERF_EN
                  StallCount <= StallCount + 32'd1;
`endif
               end else if (redirect) begin
                  Instruction <= NOP_INSTR;
                  IdValid     <= 1'b0;
`ifdef FETCH_PERF_EN
                  FlushCount  <= FlushCount + 32'd1;
`endif
                  // Without a response yet, park the target until the stale word arrives.
                  if (imem.ImemValid) begin
                     pc <= target;
                  end else begin
                     pending_pc <= target;
                     state      <= DISCARD;
                  end
               end else if (imem.ImemValid) begin
                  pc          <= pc_inc(pc);
                  Instruction <= imem.ImemData;
                  PCPlus4     <= pc_inc(pc);
                  IdValid     <= 1'b1;
`ifdef FETCH_PERF_EN
                  FetchCount  <= FetchCount + 32'd1;
`endif
               end else begin
                  Instruction <= NOP_INSTR;
                  IdValid     <= 1'b0;
               end
            end
            DISCARD: begin
               Instruction <= NOP_INSTR;
               IdValid     <= 1'b0;
               if (imem.ImemValid) begin
                  pc    <= pending_pc;
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage with a zero-wait memory model
// whose valid line the stimulus controls per cycle.
module tb_fetch_stage;
   import pipeline_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset, Stall, Branch, jump, jr;
   logic [31:0] BranchTarget, JrTarget;
   logic [31:0] Instruction, PCPlus4;
   logic        IdValid;
   logic        mem_valid;
`ifdef FETCH_PERF_EN
   logic [31:0] FetchCount, StallCount, FlushCount;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   fetch_stage_if bus ();

   // Instruction word at address a: a J-format word whose target is a + 0x100.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [25:0] idx;
      idx = a[27:2] + 26'h40;
      return {OP_J, idx};
   endfunction

   assign bus.ImemValid = mem_valid;
   assign bus.ImemData  = mem_word(bus.ImemAddr);

   fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Stall        (Stall),
      .Branch       (Branch),
      .jump         (jump),
      .jr           (jr),
      .BranchTarget (BranchTarget),
      .JrTarget     (JrTarget),
      .imem         (bus),
      .Instruction  (Instruction),
      .PCPlus4      (PCPlus4),
      .IdValid      (IdValid)
`ifdef FETCH_PERF_EN
      ,
      .FetchCount   (FetchCount),
      .StallCount   (StallCount),
      .FlushCount   (FlushCount)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        branch;
      logic        jump;
      logic        jr;
      logic        valid;
      logic [31:0] btgt;
      logic [31:0] jtgt;
      logic        req;
      logic        acc;
      logic [31:0] addr;
      logic [31:0] instr;
      logic        idv;
      logic        chk_pc4;
      logic [31:0] pc4;
   } vec_t;

   vec_t vt[23];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   // Drive one cycle of inputs (called just after a rising edge), check the
   // combinational handshake, then check the registered outputs after the edge.
   task automatic apply(input vec_t v, input int idx);
      Reset = v.rst; Stall = v.stall; Branch = v.branch; jump = v.jump; jr = v.jr;
      mem_valid = v.valid; BranchTarget = v.btgt; JrTarget = v.jtgt;
      #1;
      chk("ImemReq", idx, 32'(bus.ImemReq), 32'(v.req));
      chk("ImemAccept", idx, 32'(bus.ImemAccept), 32'(v.acc));
      @(posedge Clk); #1;
      chk("ImemAddr", idx, bus.ImemAddr, v.addr);
      chk("Instruction", idx, Instruction, v.instr);
      chk("IdValid", idx, 32'(IdValid), 32'(v.idv));
      if (v.chk_pc4) chk("PCPlus4", idx, PCPlus4, v.pc4);
   endtask

   initial begin
      //           rst stl br  jmp jr  vld btgt          jtgt          req acc addr          instr         idv cpc pc4
      vt[0]  = '{1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        1, 1, 32'h0040_0004, 32'h0810_0040, 1, 1, 32'h0040_0004};
      vt[1]  = '{1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        1, 1, 32'h0040_0008, 32'h0810_0041, 1, 1, 32'h0040_0008};
      vt[2]  = '{1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        1, 1, 32'h0040_000C, 32'h0810_0042, 1, 1, 32'h0040_000C};
      vt[3]  = '{1, 1, 0, 0, 0, 1, 32'h0,        32'h0,        1, 0, 32'h0040_000C, 32'h0810_0042, 1, 1, 32'h0040_000C};
      vt[4]  = '{1, 1, 0, 0, 0, 1, 32'h0,        32'h0,        1, 0, 32'h0040_000C, 32'h0810_0042, 1, 1, 32'h0040_000C};
      vt[5]  = '{1, 1, 0, 0, 0, 1, 32'h0,        32'h0,        1, 0, 32'h0040_000C, 32'h0810_0042, 1, 1, 32'h0040_000C};
      vt[6]  = '{1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        1, 1, 32'h0040_0010, 32'h0810_0043, 1, 1, 32'h0040_0010};
      vt[7]  = '{1, 1, 1, 0, 0, 1, 32'h0040_0100, 32'h0,       1, 0, 32'h0040_0010, 32'h0810_0043, 1, 1, 32'h0040_0010};
      vt[8]  = '{1, 0, 1, 0, 0, 1, 32'h0040_0100, 32'h0,       1, 1, 32'h0040_0100, 32'h0,         0, 0, 32'h0};
      vt[9]  = '{1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        1, 1, 32'h0040_0104, 32'h0810_0080, 1, 1, 32'h0040_0104};
      vt[10] = '{1, 0, 1, 1, 1, 1, 32'h0040_0300, 32'h0040_0200, 1, 1, 32'h0040_0200, 32'h0,      0, 0, 32'h0};
      vt[11] = '{1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        1, 1, 32'h0040_0204, 32'h0810_00C0, 1, 1, 32'h0040_0204};
      vt[12] = '{1, 0, 1, 1, 0, 1, 32'h0040_0500, 32'h0,       1, 1, 32'h0040_0300, 32'h0,         0, 0, 32'h0};
      vt[13] = '{1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h0040_0300, 32'h0,         0, 0, 32'h0};
      vt[14] = '{1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        1, 1, 32'h0040_0304, 32'h0810_0100, 1, 1, 32'h0040_0304};
      vt[15] = '{1, 0, 1, 0, 0, 0, 32'h0040_0400, 32'h0,       1, 0, 32'h0040_0304, 32'h0,         0, 0, 32'h0};
      vt[16] = '{1, 1, 1, 0, 0, 0, 32'h0040_0600, 32'h0,       1, 0, 32'h0040_0304, 32'h0,         0, 0, 32'h0};
      vt[17] = '{1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h0040_0304, 32'h0,         0, 0, 32'h0};
      vt[18] = '{1, 1, 0, 0, 0, 1, 32'h0,        32'h0,        1, 1, 32'h0040_0400, 32'h0,         0, 0, 32'h0};
      vt[19] = '{1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        1, 1, 32'h0040_0404, 32'h0810_0140, 1, 1, 32'h0040_0404};
      vt[20] = '{1, 0, 1, 0, 1, 1, 32'h0,        32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 32'h0,        0, 0, 32'h0};
      vt[21] = '{1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        1, 1, 32'h0000_0000, 32'h0800_003F, 1, 1, 32'h0000_0000};
      vt[22] = '{1, 0, 1, 1, 0, 1, 32'h0040_0500, 32'h0,       1, 1, 32'h0000_00FC, 32'h0,         0, 0, 32'h0};

      Reset = 1'b0; Stall = 1'b0; Branch = 1'b0; jump = 1'b0; jr = 1'b0;
      mem_valid = 1'b1; BranchTarget = 32'h0; JrTarget = 32'h0;

      // Reset for two edges: outputs at reset values, handshake held low.
      for (int k = 0; k < 2; k++) begin
         @(posedge Clk); #1;
         chk("rst_ImemReq", k, 32'(bus.ImemReq), 32'h0);
         chk("rst_ImemAccept", k, 32'(bus.ImemAccept), 32'h0);
         chk("rst_ImemAddr", k, bus.ImemAddr, 32'h0040_0000);
         chk("rst_Instruction", k, Instruction, 32'h0);
         chk("rst_PCPlus4", k, PCPlus4, 32'h0);
         chk("rst_IdValid", k, 32'(IdValid), 32'h0);
      end

      for (int i = 0; i < 23; i++) apply(vt[i], i);

      // Redirect into DISCARD, then reset while the response is outstanding.
      apply('{1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 1, 1, 32'h0000_0100, 32'h0800_007F, 1, 1, 32'h0000_0100}, 100);
      apply('{1, 0, 1, 0, 0, 0, 32'h0040_0800, 32'h0, 1, 0, 32'h0000_0100, 32'h0, 0, 0, 32'h0}, 101);
      apply('{0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0, 32'h0040_0000, 32'h0, 0, 1, 32'h0}, 102);
`ifdef FETCH_PERF_EN
      chk("FetchCount", 102, FetchCount, 32'h0);
      chk("StallCount", 102, StallCount, 32'h0);
      chk("FlushCount", 102, FlushCount, 32'h0);
`endif
      apply('{0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0, 32'h0040_0000, 32'h0, 0, 1, 32'h0}, 103);
      // Back in FETCH: the first response is accepted, not dropped.
      apply('{1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 1, 1, 32'h0040_0004, 32'h0810_0040, 1, 1, 32'h0040_0004}, 104);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
